// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the sequential ALU slice.
//   op_e      : 4-bit operation codes accepted on the 'op' port
//   FLG_*     : bit positions inside the 4-bit {V,C,N,Z} flags vector
//   state_e   : control FSM states of alu_seq
//   pack_flags: assembles a flags vector from individual status bits
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_SAR = 4'd7,
    OP_GTU = 4'd8,
    OP_LTS = 4'd9,
    OP_MUL = 4'd10
  } op_e;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Places the four status bits at their named indices so callers never
  // depend on the raw ordering of the flags vector.
  function automatic logic [3:0] pack_flags(input logic v, input logic c,
                                            input logic n, input logic z);
    logic [3:0] f;
    f        = '0;
    f[FLG_V] = v;
    f[FLG_C] = c;
    f[FLG_N] = n;
    f[FLG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   start      : one-cycle pulse; latches a/b and begins a new product
//   a, b       : WIDTH-bit unsigned operands (sampled only on start)
//   done       : high for one cycle once all WIDTH steps have completed
//   product    : 2*WIDTH-bit accumulator; valid while done is high
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  logic               running;

  // Multiplier datapath: on start the multiplicand is zero-extended and the
  // counter loaded with WIDTH. Each following cycle consumes the LSB of the
  // multiplier, adding the shifted multiplicand when it is set. After the
  // counter reaches zero the unit stays 'running' for one more cycle so the
  // controller sees done; the running flag then drops, making done a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
      acc     <= '0;
      count   <= COUNT_INIT;
      running <= 1'b1;
    end else if (running) begin
      if (count != '0) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count - 1'b1;
      end else begin
        running <= 1'b0;
      end
    end
  end

  assign done    = running && (count == '0);
  assign product = acc;

endmodule

// File: rtl/alu_seq.sv
// alu_seq
// Registered ALU with valid/ready handshakes on the operand and result sides.
// Single-cycle ops produce a result one edge after accept; MUL runs through
// the iterative multiplier and takes WIDTH+1 edges. One op in flight at a time.
// Ports:
//   clk, rst_n           : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake; accept on in_valid && in_ready
//   a, b                 : operands (b is the shift amount for shift ops)
//   op                   : operation code (alu_seq_pkg::op_e, 11..15 illegal)
//   out_valid / out_ready: result handshake; retire on out_valid && out_ready
//   y, y_hi              : result (y_hi is the MUL high half, else 0)
//   flags                : {V,C,N,Z}
//   err                  : the op that produced this result was illegal
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic [3:0]       flags,
  output logic             err
);

  localparam int SW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam logic [SW-1:0]    WIDTH_S = SW'(WIDTH);

  state_e state;
  state_e next_state;

  logic accept;
  logic is_mul;
  logic mul_start;
  logic mul_done;
  logic load_alu;
  logic load_mul;

  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH-1:0]   mul_lo;
  logic [WIDTH-1:0]   mul_hi;
  logic               mul_ovf;
  logic [3:0]         mul_flags;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SW-1:0]    shamt;
  logic             shift_carry_ok;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH:0]   shr_ext;
  logic [WIDTH:0]   sar_ext;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;
  logic             alu_v;
  logic             alu_err;
  logic [3:0]       alu_flags;

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mul_start),
    .a      (a),
    .b      (b),
    .done   (mul_done),
    .product(mul_product)
  );

  // Single-cycle datapath. Shifts work on a WIDTH+1 vector with one spare
  // bit on the side the data leaves, so that spare bit is the last bit
  // shifted out. The amount is clamped to WIDTH: any larger amount yields
  // the same y as WIDTH, and the carry is suppressed outside 1..WIDTH.
  always_comb begin
    sum            = {1'b0, a} + {1'b0, b};
    diff           = {1'b0, a} - {1'b0, b};
    shamt          = (b > WIDTH_V) ? WIDTH_S : b[SW-1:0];
    shift_carry_ok = (b != '0) && (b <= WIDTH_V);
    shl_ext        = {1'b0, a} << shamt;
    shr_ext        = {a, 1'b0} >> shamt;
    sar_ext        = $signed({a, 1'b0}) >>> shamt;

    alu_y   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;

    case (op)
      OP_ADD: begin
        alu_y = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_y = diff[WIDTH-1:0];
        alu_c = diff[WIDTH];
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_y = a & b;
      OP_OR:  alu_y = a | b;
      OP_XOR: alu_y = a ^ b;
      OP_SHL: begin
        alu_y = shl_ext[WIDTH-1:0];
        alu_c = shift_carry_ok && shl_ext[WIDTH];
      end
      OP_SHR: begin
        alu_y = shr_ext[WIDTH:1];
        alu_c = shift_carry_ok && shr_ext[0];
      end
      OP_SAR: begin
        alu_y = sar_ext[WIDTH:1];
        alu_c = shift_carry_ok && sar_ext[0];
      end
      OP_GTU: alu_y = {{(WIDTH-1){1'b0}}, (a > b)};
      OP_LTS: alu_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MUL: alu_y = '0;
      default: alu_err = 1'b1;
    endcase

    if (alu_err) begin
      alu_flags = '0;
    end else begin
      alu_flags = pack_flags(alu_v, alu_c, alu_y[WIDTH-1], (alu_y == '0));
    end
  end

  // MUL result split and flags: overflow means the product did not fit in
  // y, and it drives both C and V. Z and N look at the low half only.
  always_comb begin
    mul_lo    = mul_product[WIDTH-1:0];
    mul_hi    = mul_product[2*WIDTH-1:WIDTH];
    mul_ovf   = (mul_hi != '0);
    mul_flags = pack_flags(mul_ovf, mul_ovf, mul_lo[WIDTH-1], (mul_lo == '0));
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Handshake and next-state logic. In DONE the block can take a new op in
  // the same cycle the consumer retires the current one, so in_ready follows
  // out_ready there and an accept is routed exactly as it would be from IDLE.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;

    case (state)
      IDLE:    in_ready = 1'b1;
      BUSY:    in_ready = 1'b0;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: in_ready = 1'b0;
    endcase

    accept    = in_valid && in_ready;
    is_mul    = (op == OP_MUL);
    mul_start = accept && is_mul;
    load_alu  = accept && !is_mul;
    load_mul  = (state == BUSY) && mul_done;

    case (state)
      IDLE: begin
        if (accept) begin
          next_state = is_mul ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (mul_done) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (accept) begin
          next_state = is_mul ? BUSY : DONE;
        end else if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output stage. Results only change on a single-cycle accept or on MUL
  // completion, which keeps y/flags frozen while DONE is backpressured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y     <= '0;
      y_hi  <= '0;
      flags <= '0;
      err   <= 1'b0;
    end else if (load_alu) begin
      y     <= alu_y;
      y_hi  <= '0;
      flags <= alu_flags;
      err   <= alu_err;
    end else if (load_mul) begin
      y     <= mul_lo;
      y_hi  <= mul_hi;
      flags <= mul_flags;
      err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq
// Directed self-checking bench for alu_seq. An 8-bit instance carries most
// scenarios; a 16-bit instance checks the wide multiply.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk;
  logic        rst_n;

  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [3:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  y;
  logic [7:0]  y_hi;
  logic [3:0]  flags;
  logic        err;

  logic        in_valid_w;
  logic        in_ready_w;
  logic [15:0] a_w;
  logic [15:0] b_w;
  logic [3:0]  op_w;
  logic        out_valid_w;
  logic        out_ready_w;
  logic [15:0] y_w;
  logic [15:0] y_hi_w;
  logic [3:0]  flags_w;
  logic        err_w;

  int errors = 0;
  int checks = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .y_hi     (y_hi),
    .flags    (flags),
    .err      (err)
  );

  alu_seq #(.WIDTH(16)) dut_w (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid_w),
    .in_ready (in_ready_w),
    .a        (a_w),
    .b        (b_w),
    .op       (op_w),
    .out_valid(out_valid_w),
    .out_ready(out_ready_w),
    .y        (y_w),
    .y_hi     (y_hi_w),
    .flags    (flags_w),
    .err      (err_w)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one cycle of stimulus on the 8-bit instance at the falling edge
  // and returns just after the following rising edge.
  task automatic applyStimulus(input logic [3:0] o, input logic [7:0] av,
                               input logic [7:0] bv, input logic v,
                               input logic r);
    @(negedge clk);
    op        = o;
    a         = av;
    b         = bv;
    in_valid  = v;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (y !== 8'h00) begin errors++; $display("[TB] FAIL reset_y: got %h expected 00", y); end
    checks++; if (y_hi !== 8'h00) begin errors++; $display("[TB] FAIL reset_y_hi: got %h expected 00", y_hi); end
    checks++; if (flags !== 4'h0) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", flags); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (in_ready_w !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready_w: got %b expected 1", in_ready_w); end
  endtask

  task automatic test_add();
    applyStimulus(OP_ADD, 8'h7F, 8'h01, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_valid: got %b expected 1", out_valid); end
    checks++; if (y !== 8'h80) begin errors++; $display("[TB] FAIL add_y: got %h expected 80", y); end
    checks++; if (flags !== 4'b1010) begin errors++; $display("[TB] FAIL add_flags: got %b expected 1010", flags); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL add_err: got %b expected 0", err); end
    checks++; if (y_hi !== 8'h00) begin errors++; $display("[TB] FAIL add_y_hi: got %h expected 00", y_hi); end
    applyStimulus(OP_ADD, 8'hFF, 8'h01, 1'b1, 1'b1);
    checks++; if (y !== 8'h00) begin errors++; $display("[TB] FAIL add_wrap_y: got %h expected 00", y); end
    checks++; if (flags !== 4'b0101) begin errors++; $display("[TB] FAIL add_wrap_flags: got %b expected 0101", flags); end
    applyStimulus(OP_ADD, 8'h00, 8'h00, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_retire: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    applyStimulus(OP_SUB, 8'h00, 8'h01, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_sub_valid: got %b expected 1", out_valid); end
    checks++; if (y !== 8'hFF) begin errors++; $display("[TB] FAIL b2b_sub_y: got %h expected ff", y); end
    checks++; if (flags !== 4'b0110) begin errors++; $display("[TB] FAIL b2b_sub_flags: got %b expected 0110", flags); end
    applyStimulus(OP_GTU, 8'h05, 8'h03, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_gtu_valid: got %b expected 1", out_valid); end
    checks++; if (y !== 8'h01) begin errors++; $display("[TB] FAIL b2b_gtu_y: got %h expected 01", y); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("[TB] FAIL b2b_gtu_flags: got %b expected 0000", flags); end
    applyStimulus(OP_MUL, 8'h02, 8'h03, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_mul_busy_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_mul_busy_ready: got %b expected 0", in_ready); end
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(OP_ADD, 8'hAA, 8'h55, 1'b0, 1'b1);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_mul_early: got %b expected 0", out_valid); end
    applyStimulus(OP_ADD, 8'hAA, 8'h55, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_mul_valid: got %b expected 1", out_valid); end
    checks++; if (y !== 8'h06) begin errors++; $display("[TB] FAIL b2b_mul_y: got %h expected 06", y); end
    applyStimulus(OP_ADD, 8'h00, 8'h00, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_retire: got %b expected 0", out_valid); end
  endtask

  task automatic test_shifts();
    logic [3:0] t_op [6] = '{OP_SAR, OP_SAR, OP_SHL, OP_SHR, OP_SHL, OP_SHL};
    logic [7:0] t_a  [6] = '{8'h90, 8'h90, 8'h81, 8'h81, 8'h81, 8'h81};
    logic [7:0] t_b  [6] = '{8'd3,  8'd9,  8'd1,  8'd8,  8'd0,  8'd9};
    logic [7:0] t_y  [6] = '{8'hF2, 8'hFF, 8'h02, 8'h00, 8'h81, 8'h00};
    logic [3:0] t_f  [6] = '{4'b0010, 4'b0010, 4'b0100, 4'b0101, 4'b0010, 4'b0001};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(t_op[i], t_a[i], t_b[i], 1'b1, 1'b1);
      checks++; if (y !== t_y[i]) begin errors++; $display("[TB] FAIL shift%0d_y: got %h expected %h", i, y, t_y[i]); end
      checks++; if (flags !== t_f[i]) begin errors++; $display("[TB] FAIL shift%0d_flags: got %b expected %b", i, flags, t_f[i]); end
    end
    applyStimulus(OP_ADD, 8'h00, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_compare_logic();
    logic [3:0] t_op [5] = '{OP_LTS, OP_LTS, OP_GTU, OP_XOR, OP_OR};
    logic [7:0] t_a  [5] = '{8'h80, 8'h01, 8'h80, 8'hAA, 8'h0C};
    logic [7:0] t_b  [5] = '{8'h01, 8'h80, 8'h01, 8'h55, 8'h03};
    logic [7:0] t_y  [5] = '{8'h01, 8'h00, 8'h01, 8'hFF, 8'h0F};
    logic [3:0] t_f  [5] = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(t_op[i], t_a[i], t_b[i], 1'b1, 1'b1);
      checks++; if (y !== t_y[i]) begin errors++; $display("[TB] FAIL cmp%0d_y: got %h expected %h", i, y, t_y[i]); end
      checks++; if (flags !== t_f[i]) begin errors++; $display("[TB] FAIL cmp%0d_flags: got %b expected %b", i, flags, t_f[i]); end
    end
    applyStimulus(OP_ADD, 8'h00, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_mul8();
    applyStimulus(OP_MUL, 8'hFF, 8'hFF, 1'b1, 1'b1);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mul8_ready_c0: got %b expected 0", in_ready); end
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(OP_ADD, 8'h12, 8'h34, 1'b0, 1'b1);
      if (i < 8) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mul8_ready_c%0d: got %b expected 0", i, in_ready); end
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mul8_early_c%0d: got %b expected 0", i, out_valid); end
    end
    applyStimulus(OP_ADD, 8'h12, 8'h34, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL mul8_valid: got %b expected 1", out_valid); end
    checks++; if (y !== 8'h01) begin errors++; $display("[TB] FAIL mul8_y: got %h expected 01", y); end
    checks++; if (y_hi !== 8'hFE) begin errors++; $display("[TB] FAIL mul8_y_hi: got %h expected fe", y_hi); end
    checks++; if (flags !== 4'b1100) begin errors++; $display("[TB] FAIL mul8_flags: got %b expected 1100", flags); end
    applyStimulus(OP_ADD, 8'h00, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_mul16();
    @(negedge clk);
    op_w        = OP_MUL;
    a_w         = 16'h1234;
    b_w         = 16'h0010;
    in_valid_w  = 1'b1;
    out_ready_w = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready_w !== 1'b0) begin errors++; $display("[TB] FAIL mul16_busy: got %b expected 0", in_ready_w); end
    @(negedge clk);
    in_valid_w = 1'b0;
    a_w        = 16'hFFFF;
    b_w        = 16'hFFFF;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
    end
    checks++; if (out_valid_w !== 1'b0) begin errors++; $display("[TB] FAIL mul16_early: got %b expected 0", out_valid_w); end
    @(posedge clk);
    #1;
    checks++; if (out_valid_w !== 1'b1) begin errors++; $display("[TB] FAIL mul16_valid: got %b expected 1", out_valid_w); end
    checks++; if (y_w !== 16'h2340) begin errors++; $display("[TB] FAIL mul16_y: got %h expected 2340", y_w); end
    checks++; if (y_hi_w !== 16'h0001) begin errors++; $display("[TB] FAIL mul16_y_hi: got %h expected 0001", y_hi_w); end
    checks++; if (flags_w !== 4'b1100) begin errors++; $display("[TB] FAIL mul16_flags: got %b expected 1100", flags_w); end
    @(posedge clk);
    #1;
    checks++; if (out_valid_w !== 1'b0) begin errors++; $display("[TB] FAIL mul16_retire: got %b expected 0", out_valid_w); end
  endtask

  task automatic test_backpressure();
    applyStimulus(OP_AND, 8'hF0, 8'hBC, 1'b1, 1'b0);
    checks++; if (y !== 8'hB0) begin errors++; $display("[TB] FAIL bp_and_y: got %h expected b0", y); end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(OP_ADD, 8'h01, 8'h01, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp%0d_valid: got %b expected 1", i, out_valid); end
      checks++; if (y !== 8'hB0) begin errors++; $display("[TB] FAIL bp%0d_y: got %h expected b0", i, y); end
      checks++; if (flags !== 4'b0010) begin errors++; $display("[TB] FAIL bp%0d_flags: got %b expected 0010", i, flags); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp%0d_ready: got %b expected 0", i, in_ready); end
    end
    @(negedge clk);
    op        = OP_OR;
    a         = 8'h0F;
    b         = 8'h30;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready: got %b expected 1", in_ready); end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_or_valid: got %b expected 1", out_valid); end
    checks++; if (y !== 8'h3F) begin errors++; $display("[TB] FAIL bp_or_y: got %h expected 3f", y); end
    applyStimulus(OP_ADD, 8'h00, 8'h00, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_retire: got %b expected 0", out_valid); end
  endtask

  task automatic test_illegal();
    applyStimulus(4'd13, 8'h05, 8'h07, 1'b1, 1'b1);
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL ill_err: got %b expected 1", err); end
    checks++; if (y !== 8'h00) begin errors++; $display("[TB] FAIL ill_y: got %h expected 00", y); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("[TB] FAIL ill_flags: got %b expected 0000", flags); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL ill_valid: got %b expected 1", out_valid); end
    applyStimulus(OP_XOR, 8'hAA, 8'hAA, 1'b1, 1'b1);
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL ill_clear_err: got %b expected 0", err); end
    checks++; if (flags !== 4'b0001) begin errors++; $display("[TB] FAIL ill_xor_flags: got %b expected 0001", flags); end
    applyStimulus(OP_ADD, 8'h00, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_mul();
    applyStimulus(OP_ADD, 8'h01, 8'h02, 1'b1, 1'b1);
    checks++; if (y !== 8'h03) begin errors++; $display("[TB] FAIL rst_pre_y: got %h expected 03", y); end
    applyStimulus(OP_MUL, 8'h12, 8'h34, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(OP_ADD, 8'h00, 8'h00, 1'b0, 1'b1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid: got %b expected 0", out_valid); end
    checks++; if (y !== 8'h00) begin errors++; $display("[TB] FAIL rst_mid_y: got %h expected 00", y); end
    checks++; if (y_hi !== 8'h00) begin errors++; $display("[TB] FAIL rst_mid_y_hi: got %h expected 00", y_hi); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_ready: got %b expected 1", in_ready); end
    applyStimulus(OP_MUL, 8'h03, 8'h05, 1'b1, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(OP_ADD, 8'h00, 8'h00, 1'b0, 1'b1);
    end
    applyStimulus(OP_ADD, 8'h00, 8'h00, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_post_valid: got %b expected 1", out_valid); end
    checks++; if (y !== 8'h0F) begin errors++; $display("[TB] FAIL rst_post_y: got %h expected 0f", y); end
    checks++; if (y_hi !== 8'h00) begin errors++; $display("[TB] FAIL rst_post_y_hi: got %h expected 00", y_hi); end
    applyStimulus(OP_ADD, 8'h00, 8'h00, 1'b0, 1'b1);
  endtask

  // Main sequence: every scenario runs with fixed cycle counts, so the run
  // always reaches the summary line.
  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    a           = '0;
    b           = '0;
    op          = '0;
    in_valid_w  = 1'b0;
    out_ready_w = 1'b0;
    a_w         = '0;
    b_w         = '0;
    op_w        = '0;

    test_reset();
    test_add();
    test_back_to_back();
    test_shifts();
    test_compare_logic();
    test_mul8();
    test_mul16();
    test_backpressure();
    test_illegal();
    test_reset_mid_mul();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog against an unexpected stall of the main sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
